// File: rtl/mem_wb_stage.sv
// Memory-access and write-back end of the pipeline.
// A load or store is held for WAIT_CYCLES in a multi-cycle word memory, and
// the rest of the pipeline is frozen meanwhile. A MEM/WB register then
// drives the register-file write-back triple.
module mem_wb_stage #(
  parameter int unsigned MEM_WORDS   = 64,
  parameter int unsigned WAIT_CYCLES = 4,
  parameter int unsigned ADDR_BASE   = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        WB_EN,
  input  logic        MEM_R,
  input  logic        MEM_W,
  input  logic [31:0] ALU_res,
  input  logic [31:0] val_rm,
  input  logic [3:0]  dest,
  output logic        freeze,
  output logic        WB_WB_EN,
  output logic [31:0] WB_Value,
  output logic [3:0]  WB_Dest
);

  localparam int unsigned IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      rd_q, rd_d;

  logic             wb_en_q, wb_en_d;
  logic             mem_r_q, mem_r_d;
  logic [31:0]      alu_q, alu_d;
  logic [31:0]      rdata_q, rdata_d;
  logic [3:0]       dst_q, dst_d;

  logic [31:0]      mem_q [MEM_WORDS];

  logic             req;
  logic             commit;
  logic [IDX_W-1:0] idx;

  assign req = MEM_R | MEM_W;
  // Byte offset from the base, word-aligned, wrapped to the memory size.
  assign idx = IDX_W'((ALU_res - 32'(ADDR_BASE)) >> 2);

  // Access sequencer: request detect, latency count-down, commit, then one
  // DONE cycle so the still-present request is not restarted.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (req) begin
          state_d = ACCESS;
          cnt_d   = CNT_W'(WAIT_CYCLES - 1);
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          commit  = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    freeze = ((state_q == IDLE) && req) || (state_q == ACCESS);
  end

  // Read register captures the addressed word at commit (pre-write contents
  // when a store happens in the same edge).
  always_comb begin
    rd_d = rd_q;
    if (commit) begin
      rd_d = mem_q[idx];
    end
  end

  // MEM/WB register: normal load when not frozen, bubble otherwise.
  always_comb begin
    wb_en_d = 1'b0;
    mem_r_d = mem_r_q;
    alu_d   = alu_q;
    rdata_d = rdata_q;
    dst_d   = dst_q;
    if (!freeze) begin
      wb_en_d = WB_EN;
      mem_r_d = MEM_R;
      alu_d   = ALU_res;
      rdata_d = rd_q;
      dst_d   = dest;
    end
  end

  // State, counter, read register and MEM/WB register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rd_q    <= '0;
      wb_en_q <= 1'b0;
      mem_r_q <= 1'b0;
      alu_q   <= '0;
      rdata_q <= '0;
      dst_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      wb_en_q <= wb_en_d;
      mem_r_q <= mem_r_d;
      alu_q   <= alu_d;
      rdata_q <= rdata_d;
      dst_q   <= dst_d;
    end
  end

  // Data memory write port; contents survive reset, but a reset edge
  // suppresses any commit.
  always_ff @(posedge clk) begin
    if (!rst && commit && MEM_W) begin
      mem_q[idx] <= val_rm;
    end
  end

  assign WB_WB_EN = wb_en_q;
  assign WB_Dest  = dst_q;
  assign WB_Value = mem_r_q ? rdata_q : alu_q;

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Memory-access and write-back end of the ARM pipeline: consumes the fields registered by the execute-stage pipeline register (ALU_res, val_rm, dest, MEM_R, MEM_W, WB_EN). It performs data-memory loads and stores against an internal multi-cycle word memory, holds the pipeline with `freeze` while an access is in flight, and holds a MEM/WB pipeline register. It drives the write-back triple (WB_WB_EN, WB_Value, WB_Dest) that the decode stage's register file consumes.

## Interface
- MEM_WORDS, 64, number of 32-bit words in data memory (power of 2)
- WAIT_CYCLES, 4, access latency in cycles (≥1)
- ADDR_BASE, 1024, byte address mapped to word 0
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset; one clock; reset is synchronous and active-high
- WB_EN  in  1  instruction writes a register
- MEM_R  in  1  load
- MEM_W  in  1  store
- ALU_res  in  32  ALU result / byte address
- val_rm  in  32  store data
- dest  in  4  destination register
- freeze  out  1  stall request to IF/ID/EXE stages and their pipeline registers
- WB_WB_EN  out  1  register-file write enable
- WB_Value  out  32  write-back data
- WB_Dest  out  4  write-back register

## Operation
- Word index = ((ALU_res − ADDR_BASE) >> 2) mod MEM_WORDS; bits [1:0] ignored; out-of-range addresses wrap.
- FSM states: IDLE, ACCESS, DONE.
  - IDLE: if MEM_R|MEM_W → ACCESS, counter ← WAIT_CYCLES−1; else stay.
  - ACCESS: counter decrements each cycle; at counter==0 commit (store writes val_rm; load latches word into read register) → DONE.
  - DONE: → IDLE unconditionally (the still-present request is not restarted).
- freeze = (IDLE & (MEM_R|MEM_W)) | ACCESS; combinational, so upstream holds inputs stable from the first cycle of a request.
- MEM/WB register loads when freeze==0: wb_en←WB_EN, mem_r←MEM_R, alu←ALU_res, rdata←read register (load) , dst←dest. When freeze==1 it loads a bubble (wb_en←0).
- WB_WB_EN = registered wb_en; WB_Dest = dst; WB_Value = mem_r ? rdata : alu.
- MEM_R and MEM_W both 1: treated as store; read register latches pre-write contents.
- Store with WB_EN=1 still writes back ALU_res.
- Memory contents are not cleared by rst.

## Timing
- Reset: state IDLE, counter 0, read register 0, MEM/WB register 0 → freeze=0 (absent request), WB_WB_EN=0, WB_Value=0, WB_Dest=0.
- Non-memory instruction presented in cycle t: write-back outputs valid in t+1; freeze never asserted.
- Memory instruction first presented in cycle t: freeze high t..t+WAIT_CYCLES (WAIT_CYCLES+1 cycles); commit at edge ending t+WAIT_CYCLES; DONE in t+WAIT_CYCLES+1 with freeze=0; write-back valid in t+WAIT_CYCLES+2.
- Back-to-back memory instructions: second one seen in IDLE the cycle after DONE; no lost or duplicated access.
- Bubbles during freeze: WB_WB_EN=0 on every cycle from t+1 to t+WAIT_CYCLES+1.
- rst during ACCESS before commit edge: access aborted, memory unchanged, FSM IDLE next cycle.
- Inputs sampled only in IDLE (request detect), at commit edge (address/data) and in DONE (MEM/WB load); changes while frozen are a protocol violation.

## Test plan
- Reset with MEM_R=MEM_W=0 → freeze=0, WB_WB_EN=0, WB_Value=0, WB_Dest=0 next cycle.
- ALU op: WB_EN=1, ALU_res=0x12345678, dest=3 at t → t+1 WB_WB_EN=1, WB_Value=0x12345678, WB_Dest=3; freeze stays 0.
- Store then load: MEM_W, ALU_res=1028, val_rm=0xDEADBEEF → freeze high 5 cycles; then MEM_R, WB_EN=1, ALU_res=1028, dest=5 → freeze 5 cycles, WB_Value=0xDEADBEEF, WB_Dest=5 at t+6, WB_WB_EN=0 during t+1..t+5.
- Wrap: store 0xA5A5A5A5 at ALU_res=1024+4×64=1280, load from 1024 → 0xA5A5A5A5; load from 1027 returns same word.
- Simultaneous MEM_R/MEM_W at word holding 0x1 with val_rm=0x2 → WB_Value (if WB_EN) =0x1 via read path, subsequent load returns 0x2.
- rst asserted in 2nd ACCESS cycle of store 0x77 to 1032 → freeze 0 next cycle, later load of 1032 returns prior contents.
